threshold_scheduler: RTL and testbench

THRESHOLD_SCHEDULER -- requirements
Module: threshold_scheduler

---
 rtl/threshold_scheduler_pkg.sv | 29 ++
 rtl/rr_next_sel.sv | 25 ++
 rtl/threshold_scheduler.sv | 169 ++++++++++++++++
 tb/tb_threshold_scheduler.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/threshold_scheduler_pkg.sv
// Shared definitions for the threshold scheduler: config field indices, FSM states and the
// per-profile record kept in the shadow table and the active register set.
package threshold_scheduler_pkg;

  localparam logic [2:0] FldHLo  = 3'd0;
  localparam logic [2:0] FldHHi  = 3'd1;
  localparam logic [2:0] FldSLo  = 3'd2;
  localparam logic [2:0] FldSHi  = 3'd3;
  localparam logic [2:0] FldVMin = 3'd4;
  localparam logic [2:0] FldDwell = 3'd5;
  localparam logic [2:0] FldEn   = 3'd6;

  typedef enum logic [1:0] {
    StIdle,
    StSync,
    StRun
  } state_e;

  typedef struct packed {
    logic [7:0] h_lo;
    logic [7:0] h_hi;
    logic [7:0] s_lo;
    logic [7:0] s_hi;
    logic [5:0] v_min;
    logic [7:0] dwell;
    logic       en;
  } prof_t;

endpackage

// File: rtl/rr_next_sel.sv
// Round-robin pick of the first set request strictly after start, wrapping; start itself is
// considered last. none is set when no request bit is high.
module rr_next_sel #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         none
);

  always_comb begin
    idx  = start;
    none = 1'b1;
    // Walk from farthest to nearest so the nearest hit is the one that sticks.
    for (int unsigned k = N; k >= 1; k--) begin
      if (req[(32'(start) + k) % N]) begin
        idx  = W'((32'(start) + k) % N);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/threshold_scheduler.sv
// Frame-synchronous scheduler that cycles colour-threshold profiles from a host-written shadow
// table into the active registers feeding the threshold datapath.
module threshold_scheduler
  import threshold_scheduler_pkg::*;
#(
  parameter int unsigned NPROF = 4,
  parameter int unsigned PW    = $clog2(NPROF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          end_frame_in,
  input  logic          cfg_we,
  input  logic [PW+2:0] cfg_addr,
  input  logic [7:0]    cfg_data,
  output logic [7:0]    h_lo,
  output logic [7:0]    h_hi,
  output logic [7:0]    s_lo,
  output logic [7:0]    s_hi,
  output logic [5:0]    v_min,
  output logic          h_wrap,
  output logic [PW-1:0] prof_id,
  output logic          active,
  output logic          frame_done,
  output logic [PW-1:0] done_id
);

  state_e        state_q, state_d;
  prof_t         shadow_q [NPROF];
  prof_t         act_q, act_d;
  logic [PW-1:0] prof_id_q, prof_id_d;
  logic          h_wrap_q, h_wrap_d;
  logic [7:0]    dwell_cnt_q, dwell_cnt_d;
  logic          frame_done_q, frame_done_d;
  logic [PW-1:0] done_id_q, done_id_d;

  logic [NPROF-1:0] en_vec;
  logic             any_en;
  logic [PW-1:0]    rr_start, rr_idx;
  logic             rr_none;
  logic [7:0]       max_dwell, cnt_inc;
  logic [PW-1:0]    sel;
  logic             do_load;

  wire [PW-1:0] wr_prof = cfg_addr[PW+2:3];
  wire [2:0]    wr_fld  = cfg_addr[2:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(NPROF); i++) shadow_q[i] <= '0;
    end else if (cfg_we && (32'(wr_prof) < NPROF)) begin
      case (wr_fld)
        FldHLo:   shadow_q[wr_prof].h_lo  <= cfg_data;
        FldHHi:   shadow_q[wr_prof].h_hi  <= cfg_data;
        FldSLo:   shadow_q[wr_prof].s_lo  <= cfg_data;
        FldSHi:   shadow_q[wr_prof].s_hi  <= cfg_data;
        FldVMin:  shadow_q[wr_prof].v_min <= cfg_data[5:0];
        FldDwell: shadow_q[wr_prof].dwell <= cfg_data;
        FldEn:    shadow_q[wr_prof].en    <= cfg_data[0];
        default:  ;
      endcase
    end
  end

  always_comb begin
    en_vec = '0;
    for (int i = 0; i < int'(NPROF); i++) en_vec[i] = shadow_q[i].en;
  end
  assign any_en = |en_vec;

  // Starting from NPROF-1 makes the round-robin search yield the lowest enabled index.
  assign rr_start = (state_q == StRun) ? prof_id_q : PW'(NPROF - 1);

  rr_next_sel #(
    .N(NPROF),
    .W(PW)
  ) u_rr_next_sel (
    .req  (en_vec),
    .start(rr_start),
    .idx  (rr_idx),
    .none (rr_none)
  );

  assign max_dwell = (act_q.dwell == 8'd0) ? 8'd1 : act_q.dwell;
  assign cnt_inc   = dwell_cnt_q + 8'd1;

  always_comb begin
    state_d      = state_q;
    act_d        = act_q;
    prof_id_d    = prof_id_q;
    h_wrap_d     = h_wrap_q;
    dwell_cnt_d  = dwell_cnt_q;
    frame_done_d = 1'b0;
    done_id_d    = done_id_q;
    sel          = rr_idx;
    do_load      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (any_en) state_d = StSync;
      end
      StSync: begin
        if (rr_none) begin
          state_d = StIdle;
        end else if (end_frame_in) begin
          state_d     = StRun;
          dwell_cnt_d = '0;
          do_load     = 1'b1;
        end
      end
      StRun: begin
        if (end_frame_in) begin
          frame_done_d = 1'b1;
          done_id_d    = prof_id_q;
          if (rr_none) begin
            state_d     = StIdle;
            dwell_cnt_d = '0;
          end else if (cnt_inc >= max_dwell || !en_vec[prof_id_q]) begin
            // A disabled active profile is skipped rather than reloaded.
            dwell_cnt_d = '0;
            do_load     = 1'b1;
          end else begin
            dwell_cnt_d = cnt_inc;
            sel         = prof_id_q;
            do_load     = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (do_load) begin
      act_d     = shadow_q[sel];
      prof_id_d = sel;
      h_wrap_d  = shadow_q[sel].h_lo > shadow_q[sel].h_hi;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      act_q        <= '0;
      prof_id_q    <= '0;
      h_wrap_q     <= 1'b0;
      dwell_cnt_q  <= '0;
      frame_done_q <= 1'b0;
      done_id_q    <= '0;
    end else begin
      state_q      <= state_d;
      act_q        <= act_d;
      prof_id_q    <= prof_id_d;
      h_wrap_q     <= h_wrap_d;
      dwell_cnt_q  <= dwell_cnt_d;
      frame_done_q <= frame_done_d;
      done_id_q    <= done_id_d;
    end
  end

  assign h_lo       = act_q.h_lo;
  assign h_hi       = act_q.h_hi;
  assign s_lo       = act_q.s_lo;
  assign s_hi       = act_q.s_hi;
  assign v_min      = act_q.v_min;
  assign h_wrap     = h_wrap_q;
  assign prof_id    = prof_id_q;
  assign active     = (state_q == StRun);
  assign frame_done = frame_done_q;
  assign done_id    = done_id_q;

endmodule

// File: tb/tb_threshold_scheduler.sv
// Directed bench for threshold_scheduler: a vector table for the round-robin/dwell sequence and
// short hand-written sequences for reset, host-write timing and disable corner cases.
module tb_threshold_scheduler;

  localparam int NPROF = 4;
  localparam int PW    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          end_frame_in;
  logic          cfg_we;
  logic [PW+2:0] cfg_addr;
  logic [7:0]    cfg_data;
  logic [7:0]    h_lo, h_hi, s_lo, s_hi;
  logic [5:0]    v_min;
  logic          h_wrap;
  logic [PW-1:0] prof_id, done_id;
  logic          active, frame_done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  threshold_scheduler #(
    .NPROF(NPROF),
    .PW   (PW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .end_frame_in(end_frame_in),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .h_lo        (h_lo),
    .h_hi        (h_hi),
    .s_lo        (s_lo),
    .s_hi        (s_hi),
    .v_min       (v_min),
    .h_wrap      (h_wrap),
    .prof_id     (prof_id),
    .active      (active),
    .frame_done  (frame_done),
    .done_id     (done_id)
  );

  typedef struct {
    logic       efi;
    logic [1:0] prof;
    logic       done;
    logic [1:0] did;
    logic       act;
  } vec_t;

  vec_t tbl [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wr(input int p, input int f, input int d);
    cfg_we   = 1'b1;
    cfg_addr = {2'(p), 3'(f)};
    cfg_data = 8'(d);
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic efi();
    end_frame_in = 1'b1;
    tick();
    end_frame_in = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; end_frame_in = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;

    // Round-robin table: p0 dwell 1, p2 dwell 2, starting in SYNC.
    tbl[0] = '{1'b1, 2'd0, 1'b0, 2'd0, 1'b1};
    tbl[1] = '{1'b0, 2'd0, 1'b0, 2'd0, 1'b1};
    tbl[2] = '{1'b1, 2'd2, 1'b1, 2'd0, 1'b1};
    tbl[3] = '{1'b0, 2'd2, 1'b0, 2'd0, 1'b1};
    tbl[4] = '{1'b1, 2'd2, 1'b1, 2'd2, 1'b1};
    tbl[5] = '{1'b1, 2'd0, 1'b1, 2'd2, 1'b1};
    tbl[6] = '{1'b1, 2'd2, 1'b1, 2'd0, 1'b1};
    tbl[7] = '{1'b0, 2'd2, 1'b0, 2'd0, 1'b1};
    tbl[8] = '{1'b1, 2'd2, 1'b1, 2'd2, 1'b1};

    tick();
    do_reset();
    chk("rst_active", 32'(active), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_prof_id", 32'(prof_id), 0);
    chk("rst_h_lo", 32'(h_lo), 0);
    chk("rst_h_wrap", 32'(h_wrap), 0);
    chk("rst_v_min", 32'(v_min), 0);

    efi();
    chk("idle_efi_done", 32'(frame_done), 0);
    chk("idle_efi_active", 32'(active), 0);

    // Wrapped hue profile 0.
    wr(0, 0, 245); wr(0, 1, 5); wr(0, 2, 115); wr(0, 3, 210); wr(0, 4, 30); wr(0, 6, 1);
    chk("sync_active", 32'(active), 0);
    tick();
    efi();
    chk("load_active", 32'(active), 1);
    chk("load_prof", 32'(prof_id), 0);
    chk("load_h_wrap", 32'(h_wrap), 1);
    chk("load_h_lo", 32'(h_lo), 245);
    chk("load_h_hi", 32'(h_hi), 5);
    chk("load_s_lo", 32'(s_lo), 115);
    chk("load_s_hi", 32'(s_hi), 210);
    chk("load_v_min", 32'(v_min), 30);
    chk("load_no_done", 32'(frame_done), 0);

    // Host writes must not disturb the active set until a load.
    wr(0, 0, 10);
    chk("midwr_h_lo", 32'(h_lo), 245);
    tick();
    chk("midwr_h_lo2", 32'(h_lo), 245);
    efi();
    chk("reload_h_lo", 32'(h_lo), 10);
    chk("reload_done", 32'(frame_done), 1);
    chk("reload_did", 32'(done_id), 0);
    chk("reload_wrap", 32'(h_wrap), 1);
    cfg_we = 1'b1; cfg_addr = {2'd0, 3'd0}; cfg_data = 8'd20; end_frame_in = 1'b1;
    tick();
    cfg_we = 1'b0; end_frame_in = 1'b0;
    chk("samecyc_h_lo", 32'(h_lo), 10);
    chk("samecyc_done", 32'(frame_done), 1);
    tick();
    chk("pulse_width", 32'(frame_done), 0);
    wr(0, 1, 100);
    chk("midwr_wrap", 32'(h_wrap), 1);
    efi();
    chk("late_h_lo", 32'(h_lo), 20);
    chk("late_wrap", 32'(h_wrap), 0);

    // Round-robin with dwell.
    do_reset();
    wr(0, 5, 1); wr(0, 0, 11); wr(0, 6, 1);
    wr(2, 5, 2); wr(2, 0, 33); wr(2, 6, 1);
    tick();
    for (int i = 0; i < 9; i++) begin
      end_frame_in = tbl[i].efi;
      tick();
      end_frame_in = 1'b0;
      chk($sformatf("tbl%0d_prof", i), 32'(prof_id), 32'(tbl[i].prof));
      chk($sformatf("tbl%0d_done", i), 32'(frame_done), 32'(tbl[i].done));
      chk($sformatf("tbl%0d_act", i), 32'(active), 32'(tbl[i].act));
      if (tbl[i].done) chk($sformatf("tbl%0d_did", i), 32'(done_id), 32'(tbl[i].did));
    end
    chk("rr_h_lo", 32'(h_lo), 33);

    // Clearing all enables mid-frame: current frame finishes, then IDLE.
    wr(0, 6, 0); wr(2, 6, 0);
    tick();
    chk("clr_still_active", 32'(active), 1);
    efi();
    chk("clr_done", 32'(frame_done), 1);
    chk("clr_did", 32'(done_id), 2);
    chk("clr_active", 32'(active), 0);
    tick();
    efi();
    chk("clr_no_done", 32'(frame_done), 0);
    chk("clr_idle", 32'(active), 0);

    // Reset mid-RUN coinciding with a frame end.
    do_reset();
    wr(1, 0, 50); wr(1, 6, 1);
    tick();
    efi();
    chk("p1_prof", 32'(prof_id), 1);
    chk("p1_h_lo", 32'(h_lo), 50);
    tick();
    rst = 1'b0; end_frame_in = 1'b1;
    tick();
    rst = 1'b1; end_frame_in = 1'b0;
    chk("mrst_active", 32'(active), 0);
    chk("mrst_done", 32'(frame_done), 0);
    chk("mrst_prof", 32'(prof_id), 0);
    chk("mrst_h_lo", 32'(h_lo), 0);
    tick();
    efi();
    chk("mrst_stay_idle", 32'(active), 0);
    chk("mrst_stay_nodone", 32'(frame_done), 0);

    // Single profile 3 with dwell 0 reloads every frame.
    wr(3, 0, 77); wr(3, 6, 1);
    tick();
    efi();
    chk("p3_prof", 32'(prof_id), 3);
    chk("p3_first_nodone", 32'(frame_done), 0);
    for (int i = 0; i < 3; i++) begin
      efi();
      chk($sformatf("p3_f%0d_prof", i), 32'(prof_id), 3);
      chk($sformatf("p3_f%0d_done", i), 32'(frame_done), 1);
      chk($sformatf("p3_f%0d_did", i), 32'(done_id), 3);
      tick();
      chk($sformatf("p3_f%0d_low", i), 32'(frame_done), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
